// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run-time monitor: the control FSM
// state encoding and the default RAM window that arms the monitor.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } MonState;

    localparam logic [31:0] DEFAULT_WIN_LO = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_WIN_HI = 32'h8FFF_FFFF;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO. Read and write pointers carry one extra wrap bit so
// that equal pointers mean empty and pointers differing only in the wrap bit
// mean full. The head is read combinationally from storage, so a byte written
// into an empty FIFO is visible one cycle after the write.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;
    logic        doPush;
    logic        doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    assign head_o = mem_q[rdPtr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_q + {{AW{1'b0}}, doPush};
            rdPtr_q <= rdPtr_q + {{AW{1'b0}}, doPop};
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run-time monitor that sits beside the core. It arms when the PC first lands
// in the RAM window, counts retired instructions up to a run-time limit, and
// captures per-channel byte streams into FIFOs that are drained round-robin
// through a single valid/ready port.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 64,
    parameter int PC_W       = 32,
    parameter logic [PC_W-1:0] WIN_LO = PC_W'(DEFAULT_WIN_LO),
    parameter logic [PC_W-1:0] WIN_HI = PC_W'(DEFAULT_WIN_HI),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_W-1:0]     pc,
    input  logic                instr_retire,
    input  logic [CNT_W-1:0]    limit,
    input  logic                restart,
    input  logic [NUM_CH-1:0]   ch_valid,
    input  logic [8*NUM_CH-1:0] ch_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic [CH_W-1:0]     out_ch,
    output logic                armed,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic [NUM_CH-1:0]   overflow
);

    MonState            state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               armed_q;
    logic               done_q;
    logic               inWindow;

    logic [NUM_CH-1:0]  fifoFull;
    logic [NUM_CH-1:0]  fifoEmpty;
    logic [NUM_CH-1:0]  fifoPush;
    logic [NUM_CH-1:0]  fifoPop;
    logic [7:0]         fifoHead [NUM_CH];
    logic [NUM_CH-1:0]  overflow_q;

    logic [CH_W-1:0]    rrPtr_q;
    logic [CH_W-1:0]    rrPtr_d;
    logic               lock_q;
    logic [CH_W-1:0]    lockCh_q;
    logic               selValid;
    logic [CH_W-1:0]    selCh;
    logic [7:0]         selData;
    logic               popGo;

    assign inWindow = (pc >= WIN_LO) && (pc <= WIN_HI);
    assign count_d  = count_q + CNT_W'(instr_retire);

    // Control FSM: arm on the window hit, count retires, freeze when the limit is reached.
    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            state_q <= IDLE;
            count_q <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inWindow) begin
                        state_q <= RUN;
                        armed_q <= 1'b1;
                    end
                end
                RUN: begin
                    count_q <= count_d;
                    if (count_d == limit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    armed_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign armed = armed_q;
    assign done  = done_q;
    assign count = count_q;

    // Grant selection: a stalled grant is held, otherwise search from the RR pointer upward, then wrap.
    always_comb begin
        selValid = 1'b0;
        selCh    = '0;
        if (lock_q) begin
            selValid = 1'b1;
            selCh    = lockCh_q;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!selValid && !fifoEmpty[k] && (CH_W'(k) >= rrPtr_q)) begin
                    selValid = 1'b1;
                    selCh    = CH_W'(k);
                end
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (!selValid && !fifoEmpty[k] && (CH_W'(k) < rrPtr_q)) begin
                    selValid = 1'b1;
                    selCh    = CH_W'(k);
                end
            end
        end
    end

    // Head mux plus per-channel push/pop decisions; a full FIFO accepts a byte only while it is being popped.
    always_comb begin
        selData  = 8'h00;
        popGo    = selValid && out_ready;
        fifoPop  = '0;
        fifoPush = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (selCh == CH_W'(k)) begin
                selData = fifoHead[k];
            end
            fifoPop[k]  = popGo && (selCh == CH_W'(k));
            fifoPush[k] = ch_valid[k] && (!fifoFull[k] || fifoPop[k]);
        end
        rrPtr_d = rrPtr_q;
        if (popGo) begin
            rrPtr_d = (selCh == CH_W'(NUM_CH - 1)) ? '0 : selCh + CH_W'(1);
        end
    end

    assign out_valid = selValid;
    assign out_data  = selValid ? selData : 8'h00;
    assign out_ch    = selValid ? selCh : '0;

    // Arbiter state: RR pointer advances past each popped channel; the grant locks while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rrPtr_q  <= '0;
            lock_q   <= 1'b0;
            lockCh_q <= '0;
        end else begin
            rrPtr_q  <= rrPtr_d;
            lock_q   <= selValid && !out_ready;
            lockCh_q <= selCh;
        end
    end

    // Sticky drop flags, one per channel, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_q | (ch_valid & fifoFull & ~fifoPop);
        end
    end

    assign overflow = overflow_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        byte_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) uFifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (fifoPush[k]),
            .data_i  (ch_data[8*k +: 8]),
            .pop_i   (fifoPop[k]),
            .full_o  (fifoFull[k]),
            .empty_o (fifoEmpty[k]),
            .head_o  (fifoHead[k])
        );
    end

endmodule
